uart_rx_ovs: RTL and testbench
==============================

Name: uart_rx_ovs

Overview:
Parametrised UART receiver. Successor to the fixed 8N1 receiver.
- Adds configurable data width and oversampling ratio.
- Adds runtime parity and stop-bit modes, 3-sample majority voting and a false-start filter.
- Adds parity, framing, overrun and break reporting.
- Sits between the RX pin and the RX FIFO write port, clocked on the system clock, with bit timing taken from an external baud-tick enable.

Parameters:
OVS, 16, oversampling ticks per bit; even, >= 8
DATA_W, 8, data bits per frame; 5..9
SYNC_STAGES, 2, flops in the uart_rx_i synchroniser; >= 2

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  reset, asynchronous, active-low
rx_en_i  in  1  receiver enable
tick_i  in  1  one-cycle enable at OVS x baud rate
cfg_parity_en_i  in  1  1 = parity bit present
cfg_parity_odd_i  in  1  1 = odd parity, 0 = even parity
cfg_stop2_i  in  1  1 = two stop bits
uart_rx_i  in  1  asynchronous serial line, idle high
rx_fifo_data_o  out  DATA_W  received word, LSB first on the line
rx_fifo_wr_en_o  out  1  one-cycle write strobe
rx_fifo_full_i  in  1  FIFO full
parity_err_o  out  1  pulse, coincident with its write strobe
frame_err_o  out  1  pulse, coincident with its write strobe
overrun_o  out  1  pulse: word dropped because FIFO was full
break_o  out  1  pulse: break condition detected
busy_o  out  1  frame in progress (any state except IDLE)

Behaviour:
- Reset (async assert, sync deassert via rst_n_i):
  - all outputs 0, rx_fifo_data_o = 0;
  - FSM = IDLE; synchroniser flops preset to 1.
- Input synchronisation: uart_rx_i passes through SYNC_STAGES flops; all logic uses the synchronised value.
- Timing: only tick_i cycles advance the tick counter ctr (0..OVS-1). A bit period is OVS ticks.
- Sampling and vote:
  - samples taken at ctr = OVS/2-1, OVS/2 and OVS/2+1;
  - bit value = majority of the 3 samples, resolved at ctr = OVS/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE:
  - on a synchronised low while rx_en_i = 1: latch cfg_* for the whole frame, ctr = 0, go to START.
- START:
  - voted value 1 → false start; return to IDLE with no outputs.
  - otherwise continue; at ctr = OVS-1 go to DATA with bit index 0.
- DATA:
  - shift the voted bit into the shift register LSB first;
  - after DATA_W bits go to PARITY if parity is enabled, else STOP.
- PARITY:
  - expected parity = XOR of data, inverted for odd parity;
  - a mismatch sets an internal perr flag.
- STOP:
  - voted stop bit 0 sets an internal ferr flag;
  - with cfg_stop2 latched, the second stop bit is also checked;
  - the decision is made at mid-bit (ctr = OVS/2+1) of the final stop bit; the FSM then goes to IDLE without waiting for the end of the bit.
- Completion (registered; takes effect on the clk cycle after the deciding tick). Exactly one of:
  - Break: data all 0, parity sample 0 (if enabled), first stop bit 0 → break_o pulse; no write, no frame_err_o; go to WAIT_IDLE.
  - rx_fifo_full_i = 1 → overrun_o pulse; no write; data/err flags discarded; go to IDLE.
  - Otherwise → rx_fifo_wr_en_o = 1 for one cycle with rx_fifo_data_o = word; parity_err_o = perr and frame_err_o = ferr in the same cycle; go to IDLE.
- WAIT_IDLE: stay until the synchronised line is high, then go to IDLE.
- rx_fifo_data_o holds its last written value between writes; it is not zeroed.
- Unlike the previous receiver, FIFO full never stalls reception; frames keep being received and overruns are reported.
- rx_en_i = 0:
  - in any state: abort to IDLE next cycle, no write, no error pulses, partial data discarded;
  - while disabled, IDLE does not arm.
- cfg_* changes mid-frame have no effect until the next start.
- tick_i absent: FSM holds its state indefinitely.

Test Plan:
1. OVS=16, DATA_W=8, tick_i every cycle, 8N1, send 0xA5 with a 1-tick low spike at mid data bit 0 → exactly one wr strobe, data 0xA5 (spike rejected), no error pulses; strobe 154 ticks after the synchronised falling edge, then busy_o = 0.
2. Even parity, send 0x07 with parity bit 0 (wrong) → write of 0x07 with parity_err_o = 1 in the same cycle; with parity bit 1 (correct) → parity_err_o = 0. Odd parity, 0x07 with parity bit 0 → no error.
3. Line low for 5 ticks then high → false start: no wr_en, no error pulses, busy_o back to 0 within OVS/2+2 ticks; a following valid 0x3C is received correctly.
4. Send 0x5A with stop bit 0 → write 0x5A with frame_err_o = 1. Hold the line low for 12 bit times → break_o single pulse, no write; no new frame until the line is high and a fresh falling edge occurs.
5. rx_fifo_full_i = 1 during the completion of 0x11 → overrun_o pulse, no wr_en. Release full and send 0x22 → normal write of 0x22.
6. Deassert rx_en_i mid data bit 4, or assert rst_n_i mid-frame → immediate IDLE, all outputs 0, no write. Re-enable and send 0xFF with 2 stop bits → write 0xFF, no errors.

Source files
------------

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver with configurable data width and tick ratio.
// It takes runtime parity and stop-bit modes and uses a 3-sample majority
// vote per bit. It reports parity, framing, overrun and break conditions.
// Complete words are written to the RX FIFO port as a one-cycle strobe.
module uart_rx_ovs #(
    parameter int OVS         = 16,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              rx_en_i,
    input  logic              tick_i,
    input  logic              cfg_parity_en_i,
    input  logic              cfg_parity_odd_i,
    input  logic              cfg_stop2_i,
    input  logic              uart_rx_i,
    output logic [DATA_W-1:0] rx_fifo_data_o,
    output logic              rx_fifo_wr_en_o,
    input  logic              rx_fifo_full_i,
    output logic              parity_err_o,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              break_o,
    output logic              busy_o
);

    localparam int CTR_W = $clog2(OVS);
    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [CTR_W-1:0] CTR_S0   = CTR_W'(OVS / 2 - 1);
    localparam logic [CTR_W-1:0] CTR_S1   = CTR_W'(OVS / 2);
    localparam logic [CTR_W-1:0] CTR_VOTE = CTR_W'(OVS / 2 + 1);
    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(OVS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [SYNC_STAGES-1:0]   r_sync;
    logic [CTR_W-1:0]         r_ctr;
    logic [IDX_W-1:0]         r_bit_idx;
    logic [DATA_W-1:0]        r_shift;
    logic                     r_s0;
    logic                     r_s1;
    logic                     r_par_en;
    logic                     r_par_odd;
    logic                     r_stop2;
    logic                     r_stop_idx;
    logic                     r_perr;
    logic                     r_ferr;
    logic                     r_par_zero;
    logic                     r_stop1_zero;
    logic [DATA_W-1:0]        r_data;
    logic                     r_wr;
    logic                     r_perr_o;
    logic                     r_ferr_o;
    logic                     r_ovr;
    logic                     r_brk;

    logic                     w_rx;
    logic                     w_vote;
    logic                     w_tick_vote;
    logic                     w_tick_last;
    logic                     w_done;
    logic                     w_stop1_zero;
    logic                     w_is_break;
    logic                     w_ferr_final;

    assign w_rx        = r_sync[SYNC_STAGES-1];
    assign w_vote      = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
    assign w_tick_vote = tick_i && (r_ctr == CTR_VOTE);
    assign w_tick_last = tick_i && (r_ctr == CTR_LAST);

    // With two stop bits the break test looks at the first one, which was stored earlier.
    assign w_stop1_zero = r_stop_idx ? r_stop1_zero : ~w_vote;
    assign w_is_break   = (r_shift == '0) && r_par_zero && w_stop1_zero;
    assign w_ferr_final = r_ferr | ~w_vote;

    // Input synchroniser, preset to the idle-high line level.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], uart_rx_i};
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; w_done marks the tick that decides how the frame completes.
    always_comb begin
        // NOTE: every combinational output is given a default first, so no latch is inferred.
        w_state_nxt = r_state;
        w_done      = 1'b0;
        if (!rx_en_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (!w_rx) w_state_nxt = S_START;
                end
                S_START: begin
                    if (w_tick_vote && w_vote) w_state_nxt = S_IDLE;
                    else if (w_tick_last)      w_state_nxt = S_DATA;
                end
                S_DATA: begin
                    if (w_tick_last && (r_bit_idx == IDX_LAST))
                        w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                end
                S_PARITY: begin
                    if (w_tick_last) w_state_nxt = S_STOP;
                end
                S_STOP: begin
                    if (w_tick_vote && (r_stop_idx || !r_stop2)) begin
                        w_done      = 1'b1;
                        w_state_nxt = w_is_break ? S_WAIT_IDLE : S_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (w_rx) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath: tick counter, sampling, shift register, error flags and completion pulses.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ctr        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_s0         <= 1'b1;
            r_s1         <= 1'b1;
            r_par_en     <= 1'b0;
            r_par_odd    <= 1'b0;
            r_stop2      <= 1'b0;
            r_stop_idx   <= 1'b0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
            r_par_zero   <= 1'b1;
            r_stop1_zero <= 1'b0;
            r_data       <= '0;
            r_wr         <= 1'b0;
            r_perr_o     <= 1'b0;
            r_ferr_o     <= 1'b0;
            r_ovr        <= 1'b0;
            r_brk        <= 1'b0;
        end else begin
            r_wr     <= 1'b0;
            r_perr_o <= 1'b0;
            r_ferr_o <= 1'b0;
            r_ovr    <= 1'b0;
            r_brk    <= 1'b0;

            if (r_state == S_IDLE) begin
                if (w_state_nxt == S_START) begin
                    r_par_en   <= cfg_parity_en_i;
                    r_par_odd  <= cfg_parity_odd_i;
                    r_stop2    <= cfg_stop2_i;
                    r_ctr      <= '0;
                    r_bit_idx  <= '0;
                    r_stop_idx <= 1'b0;
                    r_perr     <= 1'b0;
                    r_ferr     <= 1'b0;
                    r_par_zero <= 1'b1;
                end
            end else if (tick_i && rx_en_i) begin
                r_ctr <= (r_ctr == CTR_LAST) ? '0 : r_ctr + CTR_W'(1);
                if (r_ctr == CTR_S0) r_s0 <= w_rx;
                if (r_ctr == CTR_S1) r_s1 <= w_rx;
                case (r_state)
                    S_DATA: begin
                        if (r_ctr == CTR_VOTE) r_shift <= {w_vote, r_shift[DATA_W-1:1]};
                        if (r_ctr == CTR_LAST) r_bit_idx <= r_bit_idx + IDX_W'(1);
                    end
                    S_PARITY: begin
                        if (r_ctr == CTR_VOTE) begin
                            r_perr     <= w_vote ^ (^r_shift) ^ r_par_odd;
                            r_par_zero <= ~w_vote;
                        end
                    end
                    S_STOP: begin
                        if (r_ctr == CTR_VOTE) begin
                            r_ferr <= w_ferr_final;
                            if (!r_stop_idx) r_stop1_zero <= ~w_vote;
                        end
                        if (r_ctr == CTR_LAST) r_stop_idx <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (w_done) begin
                if (w_is_break) begin
                    r_brk <= 1'b1;
                end else if (rx_fifo_full_i) begin
                    r_ovr <= 1'b1;
                end else begin
                    r_wr     <= 1'b1;
                    r_data   <= r_shift;
                    r_perr_o <= r_perr;
                    r_ferr_o <= w_ferr_final;
                end
            end
        end
    end

    assign rx_fifo_data_o  = r_data;
    assign rx_fifo_wr_en_o = r_wr;
    assign parity_err_o    = r_perr_o;
    assign frame_err_o     = r_ferr_o;
    assign overrun_o       = r_ovr;
    assign break_o         = r_brk;
    assign busy_o          = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Testbench for uart_rx_ovs. It drives serial frames tick by tick and counts
// output events with a negedge monitor. Results are compared with a vector
// table and with a frame-level reference model.
module tb_uart_rx_ovs;

    localparam int OVS         = 16;
    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;

    logic              clk = 1'b0;
    logic              rst_n_i;
    logic              rx_en_i;
    logic              tick_i;
    logic              cfg_parity_en_i;
    logic              cfg_parity_odd_i;
    logic              cfg_stop2_i;
    logic              uart_rx_i;
    logic [DATA_W-1:0] rx_fifo_data_o;
    logic              rx_fifo_wr_en_o;
    logic              rx_fifo_full_i;
    logic              parity_err_o;
    logic              frame_err_o;
    logic              overrun_o;
    logic              break_o;
    logic              busy_o;

    always #5 clk = ~clk;

    uart_rx_ovs #(.OVS(OVS), .DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n_i),
        .rx_en_i          (rx_en_i),
        .tick_i           (tick_i),
        .cfg_parity_en_i  (cfg_parity_en_i),
        .cfg_parity_odd_i (cfg_parity_odd_i),
        .cfg_stop2_i      (cfg_stop2_i),
        .uart_rx_i        (uart_rx_i),
        .rx_fifo_data_o   (rx_fifo_data_o),
        .rx_fifo_wr_en_o  (rx_fifo_wr_en_o),
        .rx_fifo_full_i   (rx_fifo_full_i),
        .parity_err_o     (parity_err_o),
        .frame_err_o      (frame_err_o),
        .overrun_o        (overrun_o),
        .break_o          (break_o),
        .busy_o           (busy_o)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              par_en;
        logic              par_odd;
        logic              par_bit;
        logic              stop1;
        logic              stop2en;
        logic              stop2;
        logic              full;
        int                exp_wr;
        int                exp_ovr;
        int                exp_brk;
        logic              exp_perr;
        logic              exp_ferr;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor: counts strobes and records the latest write, sampled on the falling edge.
    int                cyc = 0;
    int                mon_wr = 0, mon_ovr = 0, mon_brk = 0, mon_stray = 0;
    int                t_busy_rise = 0, t_busy_fall = 0, t_wr = 0;
    logic [DATA_W-1:0] mon_data = '0;
    logic              mon_perr = 1'b0, mon_ferr = 1'b0, mon_busy_wr = 1'b0, busy_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_fifo_wr_en_o) begin
            mon_wr++;
            mon_data    = rx_fifo_data_o;
            mon_perr    = parity_err_o;
            mon_ferr    = frame_err_o;
            mon_busy_wr = busy_o;
            t_wr        = cyc;
        end else if (parity_err_o || frame_err_o) begin
            mon_stray++;
        end
        if (overrun_o) mon_ovr++;
        if (break_o)   mon_brk++;
        if (busy_o && !busy_q) t_busy_rise = cyc;
        if (!busy_o && busy_q) t_busy_fall = cyc;
        busy_q = busy_o;
    end

    // Line driver: one tick slot lasts tick_div cycles, with tick_i high on its last cycle.
    int                tick_div = 1;
    logic [DATA_W-1:0] exp_last = '0;

    task automatic slots(input logic line, input int n);
        for (int k = 0; k < n; k++) begin
            uart_rx_i = line;
            for (int c = 0; c < tick_div; c++) begin
                tick_i = (c == tick_div - 1);
                @(posedge clk);
                #1;
            end
            tick_i = 1'b0;
        end
    endtask

    task automatic send_frame(input vec_t v, input bit scramble, input int glitch_bit);
        slots(1'b0, OVS);
        if (scramble) begin
            cfg_parity_en_i  = 1'($urandom);
            cfg_parity_odd_i = 1'($urandom);
            cfg_stop2_i      = 1'($urandom);
        end
        for (int i = 0; i < DATA_W; i++) begin
            if (i == glitch_bit) begin
                slots(v.data[i], OVS / 2);
                slots(~v.data[i], 1);
                slots(v.data[i], OVS / 2 - 1);
            end else begin
                slots(v.data[i], OVS);
            end
        end
        if (v.par_en)  slots(v.par_bit, OVS);
        slots(v.stop1, OVS);
        if (v.stop2en) slots(v.stop2, OVS);
        slots(1'b1, 2 * OVS);
    endtask

    task automatic apply_vec(input string name, input vec_t v, input bit scramble, input int glitch_bit);
        int w0, o0, b0, s0;
        cfg_parity_en_i  = v.par_en;
        cfg_parity_odd_i = v.par_odd;
        cfg_stop2_i      = v.stop2en;
        rx_fifo_full_i   = v.full;
        w0 = mon_wr; o0 = mon_ovr; b0 = mon_brk; s0 = mon_stray;
        send_frame(v, scramble, glitch_bit);
        rx_fifo_full_i = 1'b0;
        check($sformatf("%s_wr_count", name),  mon_wr - w0,     v.exp_wr);
        check($sformatf("%s_ovr_count", name), mon_ovr - o0,    v.exp_ovr);
        check($sformatf("%s_brk_count", name), mon_brk - b0,    v.exp_brk);
        check($sformatf("%s_stray_err", name), mon_stray - s0,  0);
        if (v.exp_wr != 0) begin
            exp_last = v.data;
            check($sformatf("%s_data", name), mon_data, v.data);
            check($sformatf("%s_perr", name), mon_perr, v.exp_perr);
            check($sformatf("%s_ferr", name), mon_ferr, v.exp_ferr);
        end else begin
            check($sformatf("%s_data_held", name), rx_fifo_data_o, exp_last);
        end
        check($sformatf("%s_busy_end", name), busy_o, 1'b0);
    endtask

    function automatic vec_t mk(input logic [DATA_W-1:0] d, input logic pe, input logic po,
                                input logic pb, input logic s1, input logic s2e, input logic s2,
                                input logic full, input int wr, input int ovr, input int brk,
                                input logic perr, input logic ferr);
        vec_t v;
        v.data = d; v.par_en = pe; v.par_odd = po; v.par_bit = pb;
        v.stop1 = s1; v.stop2en = s2e; v.stop2 = s2; v.full = full;
        v.exp_wr = wr; v.exp_ovr = ovr; v.exp_brk = brk;
        v.exp_perr = perr; v.exp_ferr = ferr;
        return v;
    endfunction

    // Frame-level reference: the outcome follows from the received fields alone.
    function automatic vec_t model(input logic [DATA_W-1:0] d, input logic pe, input logic po,
                                   input logic pb, input logic s1, input logic s2e, input logic s2,
                                   input logic full);
        vec_t v;
        logic ones_odd, perr, ferr, brk;
        ones_odd = 1'b0;
        for (int i = 0; i < DATA_W; i++) ones_odd = ones_odd ^ d[i];
        perr = pe && (pb != (po ? ~ones_odd : ones_odd));
        ferr = !s1 || (s2e && !s2);
        brk  = (d == '0) && (!pe || !pb) && !s1;
        v = mk(d, pe, po, pb, s1, s2e, s2, full, 0, 0, 0, 1'b0, 1'b0);
        if (brk) begin
            v.exp_brk = 1;
        end else if (full) begin
            v.exp_ovr = 1;
        end else begin
            v.exp_wr   = 1;
            v.exp_perr = perr;
            v.exp_ferr = ferr;
        end
        return v;
    endfunction

    vec_t tbl[14];

    initial begin
        int w0, b0, s0;
        vec_t v;

        //          data   pe    po    pb    s1    s2e   s2    full  wr ovr brk perr  ferr
        tbl[0]  = mk(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 0, 1'b1, 1'b0);
        tbl[1]  = mk(8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 0, 1'b0, 1'b0);
        tbl[2]  = mk(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 0, 1'b0, 1'b0);
        tbl[3]  = mk(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0, 1'b0, 1'b1);
        tbl[4]  = mk(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 0, 1'b0, 1'b0);
        tbl[5]  = mk(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 0, 1'b0, 1'b0);
        tbl[6]  = mk(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 0, 1'b0, 1'b1);
        tbl[7]  = mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1, 0, 0, 1'b0, 1'b0);
        tbl[8]  = mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1, 1'b0, 1'b0);
        tbl[9]  = mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 0, 1'b0, 1'b0);
        tbl[10] = mk(8'h80, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 0, 1'b1, 1'b0);
        tbl[11] = mk(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0, 1'b1, 1'b1);
        tbl[12] = mk(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1, 1'b0, 1'b0);
        tbl[13] = mk(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1, 0, 1'b0, 1'b0);

        rst_n_i = 1'b0; rx_en_i = 1'b1; tick_i = 1'b0; uart_rx_i = 1'b1;
        cfg_parity_en_i = 1'b0; cfg_parity_odd_i = 1'b0; cfg_stop2_i = 1'b0;
        rx_fifo_full_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", rx_fifo_data_o, '0);
        check("reset_strobes", {rx_fifo_wr_en_o, parity_err_o, frame_err_o, overrun_o, break_o}, 5'b0);
        check("reset_busy", busy_o, 1'b0);
        rst_n_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // 0xA5 with a one-tick spike in data bit 0; strobe 154 ticks after the start is seen.
        tick_div = 1;
        apply_vec("spike_a5", mk(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 0, 1'b0, 1'b0), 1'b0, 0);
        check("spike_a5_latency", t_wr - t_busy_rise, 154);
        check("spike_a5_busy_at_strobe", mon_busy_wr, 1'b0);

        for (int i = 0; i < 14; i++) apply_vec($sformatf("vec%0d", i), tbl[i], 1'b0, -1);

        // False start: 5 low ticks, then high.
        w0 = mon_wr; s0 = mon_stray;
        slots(1'b0, 5);
        slots(1'b1, 3 * OVS);
        check("false_start_wr", mon_wr - w0, 0);
        check("false_start_err", mon_stray - s0, 0);
        check("false_start_busy_ok", (t_busy_fall - t_busy_rise) <= (OVS / 2 + 2), 1'b1);
        apply_vec("after_false_3c", mk(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 0, 1'b0, 1'b0), 1'b0, -1);

        // Break: line low for 12 bit times; no re-arm until the line returns high.
        w0 = mon_wr; b0 = mon_brk; s0 = mon_stray;
        cfg_parity_en_i = 1'b0; cfg_stop2_i = 1'b0;
        slots(1'b0, 12 * OVS);
        check("break_pulse", mon_brk - b0, 1);
        check("break_no_wr", mon_wr - w0, 0);
        check("break_busy_waiting", busy_o, 1'b1);
        slots(1'b1, 2 * OVS);
        check("break_idle_after_high", busy_o, 1'b0);
        check("break_single", mon_brk - b0, 1);
        check("break_no_err", mon_stray - s0, 0);

        // Receiver disabled in the middle of data bit 4.
        w0 = mon_wr; s0 = mon_stray;
        slots(1'b0, OVS);
        for (int i = 0; i < 4; i++) slots(1'b1, OVS);
        slots(1'b1, OVS / 2);
        rx_en_i = 1'b0;
        @(posedge clk);
        #1;
        check("disable_busy", busy_o, 1'b0);
        slots(1'b1, 4 * OVS);
        slots(1'b0, OVS);
        slots(1'b1, 2 * OVS);
        check("disabled_no_arm", busy_o, 1'b0);
        check("disable_no_wr", mon_wr - w0, 0);
        check("disable_no_err", mon_stray - s0, 0);
        rx_en_i = 1'b1;
        apply_vec("reenable_ff", mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1, 0, 0, 1'b0, 1'b0), 1'b0, -1);

        // Asynchronous reset in the middle of a frame.
        w0 = mon_wr;
        slots(1'b0, OVS);
        slots(1'b1, OVS + OVS / 2);
        rst_n_i = 1'b0;
        #2;
        check("midrst_data", rx_fifo_data_o, '0);
        check("midrst_strobes", {rx_fifo_wr_en_o, parity_err_o, frame_err_o, overrun_o, break_o}, 5'b0);
        check("midrst_busy", busy_o, 1'b0);
        uart_rx_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n_i  = 1'b1;
        exp_last = '0;
        slots(1'b1, 2 * OVS);
        check("midrst_no_wr", mon_wr - w0, 0);
        apply_vec("after_rst_ff", mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1, 0, 0, 1'b0, 1'b0), 1'b0, -1);

        // Randomised frames against the reference model, with tick gaps, spikes and cfg churn.
        for (int n = 0; n < 30; n++) begin
            logic [DATA_W-1:0] d;
            int gb;
            d        = ($urandom_range(0, 7) == 0) ? '0 : DATA_W'($urandom);
            tick_div = $urandom_range(1, 3);
            gb       = ($urandom_range(0, 1) == 1) ? $urandom_range(0, DATA_W - 1) : -1;
            v = model(d, 1'($urandom), 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 4) != 0), 1'($urandom),
                      ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) == 0));
            apply_vec($sformatf("rand%0d", n), v, 1'b1, gb);
        end
        tick_div = 1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
